// File: rtl/nios2_dbg_pkg.sv
// Shared constants and types for the Nios II debug command synchroniser.
// Optional feature macro used by this slice: NIOS2_DBG_CMD_FIFO_EN.
package nios2_dbg_pkg;

    localparam int unsigned DBG_IR_W        = 2;
    localparam int unsigned DBG_DR_W        = 38;
    localparam int unsigned DBG_SYNC_STAGES = 2;

    // Data bit that selects act_pulse (1) or noact_pulse (0) for a command.
    localparam int unsigned DBG_QUAL_BIT    = DBG_DR_W - 1;

    // Default-width view of one captured command.
    typedef struct packed {
        logic [DBG_IR_W-1:0] ir;
        logic [DBG_DR_W-1:0] data;
    } dbg_cmd_t;

endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous strobe followed by a rising-edge
// detector. Events are suppressed until the synchronised level has been seen low
// after reset, so a strobe already high at reset release fires nothing.
module nios2_dbg_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   prev_q;
    logic                   armed_q, armed_d;
    logic                   sync_lvl;

    // Shift chains, arming logic and the edge event.
    always_comb begin
        sync_lvl = sync_q[SYNC_STAGES-1];
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_i};
        // fill_q MSB marks that sync_lvl now reflects a post-reset input sample.
        fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d  = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_lvl);
        rise_o   = sync_lvl & ~prev_q & armed_q;
    end

    // Synchroniser, edge history and arming state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= sync_lvl;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/nios2_dbg_cmd_sync.sv
// System-clock side of the Nios II JTAG debug slave: synchronises the update
// strobes, captures IR/DR, buffers commands and emits per-IR action pulses.
// Define NIOS2_DBG_CMD_FIFO_EN for the buffered FIFO with valid/ready handshake;
// otherwise the legacy unbuffered single-register behaviour is built.
module nios2_dbg_cmd_sync
    import nios2_dbg_pkg::*;
#(
    parameter int unsigned IR_W        = DBG_IR_W,
    parameter int unsigned DR_W        = DBG_DR_W,
    parameter int unsigned SYNC_STAGES = DBG_SYNC_STAGES,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        vs_uir,
    input  logic                        vs_udr,
    input  logic [IR_W-1:0]             ir_in,
    input  logic [DR_W-1:0]             sr,
    input  logic                        cmd_ready,
    input  logic                        ovf_clr,
    output logic                        cmd_valid,
    output logic [IR_W-1:0]             cmd_ir,
    output logic [DR_W-1:0]             cmd_data,
    output logic [(1<<IR_W)-1:0]        act_pulse,
    output logic [(1<<IR_W)-1:0]        noact_pulse,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int unsigned NumCh   = 1 << IR_W;
    localparam int unsigned QualBit = DR_W - 1;

    logic            uir_ev, udr_ev;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [NumCh-1:0] act_q, act_d, noact_q, noact_d;

    nios2_dbg_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_uir_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .async_i(vs_uir),
        .rise_o (uir_ev)
    );

    nios2_dbg_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_udr_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .async_i(vs_udr),
        .rise_o (udr_ev)
    );

    // Instruction capture; a same-cycle udr event still sees the old ir_q.
    always_comb begin
        ir_d = uir_ev ? ir_in : ir_q;
    end

    // Instruction register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

`ifdef NIOS2_DBG_CMD_FIFO_EN

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] data;
    } cmd_t;

    cmd_t            mem_q [FIFO_DEPTH];
    cmd_t            head;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            ovf_q, ovf_d;
    logic            full, accept, push, drop;

    // FIFO control: a full FIFO still takes a push when the head leaves this cycle.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        full     = (level_q == LvlW'(FIFO_DEPTH));
        accept   = (level_q != '0) && cmd_ready;
        push     = udr_ev && (!full || accept);
        drop     = udr_ev && full && !accept;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = accept ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !accept) begin
            level_d = level_q + LvlW'(1);
        end else if (accept && !push) begin
            level_d = level_q - LvlW'(1);
        end
        // Set has priority over clear.
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        act_d   = '0;
        noact_d = '0;
        if (accept) begin
            if (head.data[QualBit]) begin
                act_d = NumCh'(1) << head.ir;
            end else begin
                noact_d = NumCh'(1) << head.ir;
            end
        end
    end

    // Pointers, level, sticky overflow and registered pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            act_q    <= '0;
            noact_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            act_q    <= act_d;
            noact_q  <= noact_d;
        end
    end

    // Command storage; cleared on reset so the head reads zero when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{ir: ir_q, data: sr};
        end
    end

    assign cmd_valid  = (level_q != '0);
    assign cmd_ir     = head.ir;
    assign cmd_data   = head.data;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

`else

    logic [IR_W-1:0] lir_q, lir_d;
    logic [DR_W-1:0] ldata_q, ldata_d;
    logic            lvalid_q, lvalid_d;
    logic            unused_inputs;

    // Legacy capture: load on every udr event, one-cycle valid with its pulse.
    always_comb begin
        lir_d    = lir_q;
        ldata_d  = ldata_q;
        lvalid_d = udr_ev;
        act_d    = '0;
        noact_d  = '0;
        if (udr_ev) begin
            lir_d   = ir_q;
            ldata_d = sr;
            if (sr[QualBit]) begin
                act_d = NumCh'(1) << ir_q;
            end else begin
                noact_d = NumCh'(1) << ir_q;
            end
        end
    end

    // Legacy command register and pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lir_q    <= '0;
            ldata_q  <= '0;
            lvalid_q <= 1'b0;
            act_q    <= '0;
            noact_q  <= '0;
        end else begin
            lir_q    <= lir_d;
            ldata_q  <= ldata_d;
            lvalid_q <= lvalid_d;
            act_q    <= act_d;
            noact_q  <= noact_d;
        end
    end

    // Handshake inputs have no meaning without the buffer.
    assign unused_inputs = ^{cmd_ready, ovf_clr};

    assign cmd_valid  = lvalid_q;
    assign cmd_ir     = lir_q;
    assign cmd_data   = ldata_q;
    assign fifo_level = '0;
    assign overflow   = 1'b0;

`endif

    assign act_pulse   = act_q;
    assign noact_pulse = noact_q;

endmodule

// File: doc/nios2_dbg_cmd_sync.md
# nios2_dbg_cmd_sync

Parametrised system-clock side of the Nios II JTAG debug slave. It synchronises the virtual-JTAG update strobes (`vs_uir`, `vs_udr`) into `clk`, captures the instruction and data shift registers, and buffers each captured command in a FIFO with a valid/ready handshake. On each accepted command it emits one-cycle per-instruction action pulses. It replaces the fixed 2-bit-IR / 38-bit-DR sysclk block, which was unbuffered, and sits between the TCK-side shifter and the OCI memory, break and trace controllers.

## Interface
Parameters:
- `IR_W`, 2: instruction register width; 2**IR_W action channels.
- `DR_W`, 38: data register width; bit DR_W-1 is the action qualifier.
- `SYNC_STAGES`, 2: synchroniser flops per strobe, legal range 2..4.
- `FIFO_DEPTH`, 4: command FIFO entries; a power of two, at least 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `vs_uir`  in  1  update-IR strobe from the TCK domain; asynchronous.
- `vs_udr`  in  1  update-DR strobe from the TCK domain; asynchronous.
- `ir_in`  in  IR_W  instruction register; quasi-static.
- `sr`  in  DR_W  data shift register; quasi-static while `vs_udr` is high.
- `cmd_ready`  in  1  consumer accepts the head command.
- `ovf_clr`  in  1  clears `overflow`.
- `cmd_valid`  out  1  head command available.
- `cmd_ir`  out  IR_W  IR of the head command.
- `cmd_data`  out  DR_W  data of the head command (the former `jdo`).
- `act_pulse`  out  2**IR_W  one-cycle pulse, indexed by IR; accepted command with qualifier = 1.
- `noact_pulse`  out  2**IR_W  same as `act_pulse`, for qualifier = 0.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky flag: a capture was dropped.

## Operation
- Each strobe passes through a SYNC_STAGES flop chain, then a rising-edge detector. Only rising edges are events. A level held high produces one event.
- uir event: `ir_q` <= `ir_in`. The `ir_q` reset value is 0.
- udr event: push {`ir_q`, `sr`} into the FIFO.
  - If uir and udr events fall in the same cycle, the pushed IR is the old `ir_q`.
- The FIFO is first-word-fall-through. `cmd_valid` = `fifo_level` != 0. `cmd_ir` and `cmd_data` show the head entry and hold it stable until accepted.
- Accept occurs when `cmd_valid` && `cmd_ready`. `cmd_ready` while empty has no effect.
- Pulses are registered: the cycle after an accept, exactly one bit of `act_pulse` or `noact_pulse` is high for one cycle.
  - The bit index is the accepted `cmd_ir`.
  - `act_pulse` if `cmd_data`[DR_W-1] = 1, otherwise `noact_pulse`.
  - All pulse bits are 0 in every other cycle.
- Full FIFO:
  - Push with no accept in the same cycle: the push is dropped, the FIFO contents are unchanged, and `overflow` is set.
  - Push and accept in the same cycle: both complete and the level is unchanged.
- `overflow` stays set until `ovf_clr`. If set and clear occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. `fifo_level` ranges 0..FIFO_DEPTH.

## Timing
- Reset values (all asynchronous on `reset_n` low):
  - Outputs: `cmd_valid`=0, `cmd_ir`=0, `cmd_data`=0, `act_pulse`=0, `noact_pulse`=0, `fifo_level`=0, `overflow`=0.
  - Internal state: synchroniser chains cleared, edge history cleared, pointers cleared.
- Capture latency into an empty FIFO: `cmd_valid` rises on the (SYNC_STAGES+1)th `clk` edge, counting the first edge that samples `vs_udr` high.
- `sr` is sampled on the push edge. The JTAG side guarantees `sr` and `ir_in` are stable for at least SYNC_STAGES+2 `clk` cycles after the strobe rises. This block does not check that guarantee.
- Accept-to-pulse latency: 1 cycle. Back-to-back accepts produce back-to-back pulses.
- Reset asserted mid-operation discards all buffered commands and any in-flight strobe. After reset release, a strobe already high produces no event until it goes low and rises again.

## Configuration
- `NIOS2_DBG_CMD_FIFO_EN` defined: FIFO and handshake behave as described above.
- `NIOS2_DBG_CMD_FIFO_EN` undefined: legacy unbuffered mode.
  - Each udr event loads a single register.
  - `cmd_valid` pulses high for exactly one cycle, on the cycle after the load.
  - `cmd_ready` is ignored.
  - Pulses fire in the same cycle as `cmd_valid`.
  - `fifo_level` is tied to 0 and `overflow` is tied to 0.
  - `cmd_data` holds its value until the next capture.

## Structure
- Package `nios2_dbg_pkg`:
  - Default constants for IR_W, DR_W and SYNC_STAGES.
  - Packed typedef `dbg_cmd_t` {ir, data}.
  - Localparam `DBG_QUAL_BIT` = DR_W-1.
- Sub-module `nios2_dbg_sync_edge`: parametrised synchroniser plus rising-edge detector, instanced once for uir and once for udr.
- FIFO storage and pointers are inline in this block.

## Test plan
- Reset sequence: assert `reset_n`=0 mid-capture, then release -> all outputs 0, `fifo_level`=0, and no pulses until a fresh `vs_udr` rise.
- Basic command, SYNC_STAGES=2: uir with `ir_in`=2, then udr with `sr`=38'h20_0000_1234, `cmd_ready`=1 -> `cmd_valid` on the 3rd edge after `vs_udr` is sampled, `cmd_ir`=2, `cmd_data`=38'h20_0000_1234, then `act_pulse`=4'b0100 for one cycle.
- Qualifier clear: same as above with `sr`[37]=0 and `ir_in`=1 -> `noact_pulse`=4'b0010 and `act_pulse` stays 0.
- FIFO fill, FIFO_DEPTH=4, `cmd_ready`=0: five udr events with data 1..5 -> `fifo_level`=4 and `overflow`=1. Draining then yields data 1,2,3,4 in order.
- Full push with accept: FIFO full, a push arrives in the same cycle as an accept -> level stays 4 and `overflow` stays 0. Assert `ovf_clr` in the same cycle as a dropped push -> `overflow` remains 1.
- Legacy build without `NIOS2_DBG_CMD_FIFO_EN`: two udr events 10 cycles apart, `cmd_ready`=0 -> two one-cycle `cmd_valid` pulses, each with its pulse in the same cycle.
